// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding fft_256.
// Fills one bank while the FFT reads the other.
module fft_frame_buffer #(
  parameter int WIDTH = 12,
  parameter int N     = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             fft_done,
  output logic             fft_start,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  output logic             fft_busy,
  output logic             overrun,
  output logic [15:0]      frame_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [WIDTH-1:0] bank0_q [0:N-1];
  logic [WIDTH-1:0] bank1_q [0:N-1];

  logic          wr_sel_q, wr_sel_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_full_q, wr_full_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
  logic [15:0]   fc_q, fc_d;

  logic          swap;
  logic          we;
  logic          wbank;
  logic [IW-1:0] waddr;

  assign swap = wr_full_q & ~busy_q;

  // Next-state: fill pointer, bank swap/launch, busy tracking, overrun.
  always_comb begin
    wr_sel_d  = wr_sel_q;
    wr_idx_d  = wr_idx_q;
    wr_full_d = wr_full_q;
    busy_d    = busy_q;
    ovr_d     = ovr_q;
    fc_d      = fc_q;
    start_d   = swap;
    we        = 1'b0;
    wbank     = wr_sel_q;
    waddr     = wr_idx_q;
    if (swap) begin
      wr_sel_d  = ~wr_sel_q;
      wr_full_d = 1'b0;
      wr_idx_d  = '0;
      busy_d    = 1'b1;
      fc_d      = fc_q + 16'd1;
      if (sample_valid) begin
        we       = 1'b1;
        wbank    = ~wr_sel_q;
        waddr    = '0;
        wr_idx_d = IW'(1);
      end
    end else begin
      if (fft_done && busy_q) begin
        busy_d = 1'b0;
      end
      if (sample_valid) begin
        if (!wr_full_q) begin
          we = 1'b1;
          if (wr_idx_q == LAST) begin
            wr_full_d = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_full_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fc_q      <= '0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      wr_idx_q  <= wr_idx_d;
      wr_full_q <= wr_full_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      fc_q      <= fc_d;
    end
  end

  // Bank 0 storage; cleared on reset so the read side starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bank0_q[i] <= '0;
    end else if (we && !wbank) begin
      bank0_q[waddr] <= sample_in;
    end
  end

  // Bank 1 storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bank1_q[i] <= '0;
    end else if (we && wbank) begin
      bank1_q[waddr] <= sample_in;
    end
  end

  // Read bank is whichever one is not being filled.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      time_samples[k] = wr_sel_q ? bank0_q[k] : bank1_q[k];
    end
  end

  assign fft_start   = start_q;
  assign fft_busy    = busy_q;
  assign overrun     = ovr_q;
  assign frame_count = fc_q;

endmodule
